// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID circular instruction queue with first-word-fall-through head.
// Optional same-cycle IF-to-ID bypass when empty: define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_valid_i,
  input  logic [ADDR_W-1:0]            if_pc_i,
  input  logic [INST_W-1:0]            if_inst_i,
  output logic                         if_ready_o,
  input  logic                         flush_i,
  input  logic                         id_ready_i,
  output logic                         id_valid_o,
  output logic [ADDR_W-1:0]            id_pc_o,
  output logic [INST_W-1:0]            id_inst_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef IF_ID_QUEUE_BYPASS_EN
  // Empty queue shows the incoming fetch directly; if ID takes it, it never lands in storage.
  assign w_bypass      = w_empty && if_valid_i && !flush_i && !rst;
  assign w_bypass_take = w_bypass && id_ready_i;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  assign if_ready_o = !w_full;
  assign w_push     = if_valid_i && !w_full && !flush_i && !w_bypass_take;
  assign w_pop      = !w_empty && id_ready_i && !flush_i;
  assign count_o    = r_count;

  always_comb begin
    id_valid_o = 1'b0;
    id_pc_o    = '0;
    id_inst_o  = '0;
    if (!flush_i) begin
      if (!w_empty) begin
        id_valid_o = 1'b1;
        id_pc_o    = r_pc_mem[r_rd_ptr];
        id_inst_o  = r_inst_mem[r_rd_ptr];
      end else if (w_bypass) begin
        id_valid_o = 1'b1;
        id_pc_o    = if_pc_i;
        id_inst_o  = if_inst_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_pc_mem[r_wr_ptr]   <= if_pc_i;
      r_inst_mem[r_wr_ptr] <= if_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_inst_i;
  logic        if_ready_o;
  logic        flush_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .if_ready_o(if_ready_o),
    .flush_i(flush_i), .id_ready_i(id_ready_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] pc);
    if_valid_i = v;
    if_pc_i    = pc;
    if_inst_i  = inst_of(pc);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; id_ready_i = 1'b0;
    set_if(1'b1, 32'h44);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (count_o !== 3'd0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 ||
          id_inst_o !== 32'h0 || if_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL reset cyc%0d: count=%0d vld=%b pc=%h inst=%h rdy=%b, want 0 0 0 0 1",
                 c, count_o, id_valid_o, id_pc_o, id_inst_o, if_ready_o);
      end
    end
    rst = 1'b0;
    set_if(1'b0, 32'h0);
    tick();
    checks++;
    if (count_o !== 3'd0 || id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: count=%0d vld=%b rdy=%b, want 0 0 1", count_o, id_valid_o, if_ready_o);
    end
  endtask

  task automatic test_fill();
    logic [31:0] pcs [5];
    logic        exp_rdy [5];
    logic [2:0]  exp_cnt [5];
    pcs     = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    id_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_if(1'b1, pcs[i]);
      @(negedge clk);
      checks++;
      if (if_ready_o !== exp_rdy[i]) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b want %b", i, if_ready_o, exp_rdy[i]);
      end
      tick();
      checks++;
      if (count_o !== exp_cnt[i]) begin
        errors++;
        $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_o, exp_cnt[i]);
      end
    end
    set_if(1'b0, 32'h0);
    #1;
    checks++;
    if (if_ready_o !== 1'b0 || id_valid_o !== 1'b1 || id_pc_o !== 32'h00 || id_inst_o !== inst_of(32'h00)) begin
      errors++;
      $display("FAIL full_head: rdy=%b vld=%b pc=%h inst=%h, want 0 1 00000000 %h",
               if_ready_o, id_valid_o, id_pc_o, id_inst_o, inst_of(32'h00));
    end
  endtask

  task automatic test_drain_wrap();
    logic [31:0] drive [8];
    logic [31:0] head  [8];
    drive = '{32'h14, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
    head  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h14, 32'h18, 32'h1C, 32'h20};
    id_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_if(1'b1, drive[i]);
      @(negedge clk);
      checks++;
      if (id_valid_o !== 1'b1 || id_pc_o !== head[i] || id_inst_o !== inst_of(head[i])) begin
        errors++;
        $display("FAIL drain_head[%0d]: vld=%b pc=%h inst=%h want pc %h", i, id_valid_o, id_pc_o, id_inst_o, head[i]);
      end
      tick();
      checks++;
      if (count_o !== 3'd3) begin
        errors++;
        $display("FAIL drain_count[%0d]: got %0d want 3", i, count_o);
      end
    end
    set_if(1'b0, 32'h0);
    id_ready_i = 1'b0;
    #1;
    checks++;
    if (id_pc_o !== 32'h24) begin
      errors++;
      $display("FAIL drain_tail_head: got %h want 00000024", id_pc_o);
    end
  endtask

  task automatic test_flush();
    checks++;
    if (count_o !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre_count: got %0d want 3", count_o);
    end
    flush_i = 1'b1; id_ready_i = 1'b1;
    set_if(1'b1, 32'h99);
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin
      errors++;
      $display("FAIL flush_bubble: vld=%b pc=%h inst=%h want 0 0 0", id_valid_o, id_pc_o, id_inst_o);
    end
    tick();
    flush_i = 1'b0; id_ready_i = 1'b0;
    set_if(1'b0, 32'h0);
    #1;
    checks++;
    if (count_o !== 3'd0 || id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: count=%0d vld=%b rdy=%b want 0 0 1", count_o, id_valid_o, if_ready_o);
    end
  endtask

  task automatic test_bypass_latency();
    id_ready_i = 1'b1;
    set_if(1'b1, 32'h20);
    @(negedge clk);
`ifdef IF_ID_QUEUE_BYPASS_EN
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 32'h20 || id_inst_o !== inst_of(32'h20)) begin
      errors++;
      $display("FAIL bypass_same_cycle: vld=%b pc=%h want 1 00000020", id_valid_o, id_pc_o);
    end
    tick();
    set_if(1'b0, 32'h0);
    #1;
    checks++;
    if (count_o !== 3'd0 || id_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bypass_count: count=%0d vld=%b want 0 0", count_o, id_valid_o);
    end
`else
    checks++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle: vld=%b pc=%h want 0 0", id_valid_o, id_pc_o);
    end
    tick();
    set_if(1'b0, 32'h0);
    #1;
    checks++;
    if (count_o !== 3'd1 || id_valid_o !== 1'b1 || id_pc_o !== 32'h20 || id_inst_o !== inst_of(32'h20)) begin
      errors++;
      $display("FAIL nobypass_next: count=%0d vld=%b pc=%h want 1 1 00000020", count_o, id_valid_o, id_pc_o);
    end
    tick();
    checks++;
    if (count_o !== 3'd0 || id_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL nobypass_drained: count=%0d vld=%b want 0 0", count_o, id_valid_o);
    end
`endif
    id_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] head [5];
    head = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    id_ready_i = 1'b0;
    set_if(1'b1, 32'h40); tick();
    set_if(1'b1, 32'h44); tick();
    checks++;
    if (count_o !== 3'd2) begin
      errors++;
      $display("FAIL b2b_pre_count: got %0d want 2", count_o);
    end
    id_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_if(1'b1, 32'h48 + 32'(4 * i));
      @(negedge clk);
      checks++;
      if (id_valid_o !== 1'b1 || id_pc_o !== head[i] || id_inst_o !== inst_of(head[i])) begin
        errors++;
        $display("FAIL b2b_head[%0d]: vld=%b pc=%h want 1 %h", i, id_valid_o, id_pc_o, head[i]);
      end
      tick();
      checks++;
      if (count_o !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count[%0d]: got %0d want 2", i, count_o);
      end
    end
    id_ready_i = 1'b0;
    set_if(1'b0, 32'h0);
    #1;
    checks++;
    if (id_pc_o !== 32'h54) begin
      errors++;
      $display("FAIL b2b_final_head: got %h want 00000054", id_pc_o);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1; flush_i = 1'b1; id_ready_i = 1'b1;
    set_if(1'b1, 32'h60);
    tick();
    rst = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    set_if(1'b0, 32'h0);
    #1;
    checks++;
    if (count_o !== 3'd0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || if_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: count=%0d vld=%b pc=%h rdy=%b want 0 0 0 1", count_o, id_valid_o, id_pc_o, if_ready_o);
    end
    set_if(1'b1, 32'h70); tick();
    set_if(1'b0, 32'h0);
    #1;
    checks++;
    if (count_o !== 3'd1 || id_pc_o !== 32'h70) begin
      errors++;
      $display("FAIL reset_mid_restart: count=%0d pc=%h want 1 00000070", count_o, id_pc_o);
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; id_ready_i = 1'b0;
    set_if(1'b0, 32'h0);
    test_reset();
    test_fill();
    test_drain_wrap();
    test_flush();
    test_bypass_latency();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; the value SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the PC width.
REQ-003 The block SHALL have parameter INST_W, default 32, meaning the instruction width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port if_valid_i, input, 1 bit: IF presents a fetched instruction.
REQ-007 The block SHALL have port if_pc_i, input, ADDR_W bits: PC of the fetched instruction.
REQ-008 The block SHALL have port if_inst_i, input, INST_W bits: the fetched instruction word.
REQ-009 The block SHALL have port if_ready_o, output, 1 bit: the queue can accept an entry this cycle.
REQ-010 The block SHALL have port flush_i, input, 1 bit: discard all queued entries (branch or jump redirect).
REQ-011 The block SHALL have port id_ready_i, input, 1 bit: ID consumes the head entry; low means ID is stalled.
REQ-012 The block SHALL have port id_valid_o, output, 1 bit: the head entry is valid.
REQ-013 The block SHALL have port id_pc_o, output, ADDR_W bits: PC of the head entry.
REQ-014 The block SHALL have port id_inst_o, output, INST_W bits: instruction of the head entry.
REQ-015 The block SHALL have port count_o, output, $clog2(DEPTH+1) bits: current occupancy.

Function
REQ-016 The block SHALL be a circular FIFO of {pc, inst} pairs with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 A push SHALL occur when if_valid_i && if_ready_o && !flush_i; the pair SHALL be written at the write pointer, which then increments.
REQ-018 A pop SHALL occur when id_valid_o && id_ready_i && !flush_i; the read pointer SHALL then increment.
REQ-019 if_ready_o SHALL equal (count_o != DEPTH) and SHALL NOT depend combinationally on id_ready_i; when the queue is full no push is accepted, even if a pop occurs in the same cycle.
REQ-020 A push and a pop in the same cycle SHALL leave count_o unchanged; otherwise count_o SHALL change by +1 on a push and -1 on a pop.
REQ-021 The head is shown first-word-fall-through: when count_o > 0, id_valid_o SHALL be 1 and id_pc_o/id_inst_o SHALL equal the entry at the read pointer.
REQ-022 When the queue is empty (and no bypass applies, REQ-028), id_valid_o SHALL be 0 and id_pc_o/id_inst_o SHALL be all zero, forming a bubble.
REQ-023 In the cycle flush_i is high, pushes and pops SHALL be suppressed; at the next edge count_o and both pointers SHALL become 0.
REQ-024 In the cycle flush_i is high, id_valid_o SHALL be forced to 0 and id_pc_o/id_inst_o to zero.
REQ-025 Without bypass, the latency from an accepted push to id_valid_o high SHALL be 1 cycle.
REQ-026 Order SHALL be strictly preserved: entries pop in push order and none is duplicated or dropped except by flush_i or rst.

Reset
REQ-027 When rst is high at a clock edge, count_o and both pointers SHALL become 0, so that id_valid_o is 0, id_pc_o/id_inst_o are zero and if_ready_o is 1; rst SHALL take priority over flush_i, pushes and pops, including mid-stream. Storage contents need not be cleared.

Configuration
REQ-028 With IF_ID_QUEUE_BYPASS_EN defined: when count_o==0, if_valid_i==1 and flush_i==0, id_valid_o/id_pc_o/id_inst_o SHALL reflect if_valid_i/if_pc_i/if_inst_i in the same cycle; if id_ready_i is also 1, the entry SHALL be consumed and not written, leaving count_o at 0.
REQ-029 Without IF_ID_QUEUE_BYPASS_EN: there SHALL be no combinational path from the if_* inputs to the id_* outputs, and the latency SHALL be exactly 1 cycle.

Verification
REQ-030 The bench SHALL apply rst high for 2 cycles with if_valid_i=1, then release: required response is count_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0 and if_ready_o=1 during reset.
REQ-031 The bench SHALL, with DEPTH=4 and id_ready_i=0, push PCs 0x00, 0x04, 0x08, 0x0C, 0x10: required response is count_o=4, if_ready_o=0 after the 4th push, and 0x10 not accepted.
REQ-032 The bench SHALL, from full with id_ready_i=1 and if_valid_i=1, run 8 cycles: required response is the pop order 0x00, 0x04, 0x08, 0x0C followed by newer entries in order, with pointer wrap exercised and no loss.
REQ-033 The bench SHALL hold count_o=3 and assert flush_i together with if_valid_i=1 and id_ready_i=1: required response is id_valid_o=0 that cycle, count_o=0 next cycle, and the flushed-cycle instruction not enqueued.
REQ-034 The bench SHALL, from empty, push PC 0x20 with id_ready_i=1: required response is id_valid_o=1 with PC 0x20 in the same cycle and count_o=0 when bypass is enabled, or one cycle later with count_o=1 then 0 when bypass is disabled.
REQ-035 The bench SHALL, from count_o=2, run push and pop together for 5 cycles: required response is count_o=2 throughout and FIFO ordering preserved.
